// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_req_arbiter_pkg;

    localparam int ARB_ADDR_W          = 64;
    localparam int ARB_DATA_W          = 128;
    localparam int ARB_MASK_W          = ARB_DATA_W / 8;
    localparam int ARB_DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESPOND   = 2'd3
    } arb_state_t;

    // Latched request. Sized for the widest supported configuration;
    // narrower builds zero-extend into it and truncate on the way out.
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_MASK_W-1:0] wmask;
    } arb_req_t;

    // Round-robin successor with an explicit wrap (valid for any channel count).
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundles the N requester channels and the single downstream master port.
// 'master' is the arbiter's view, 'slave' is the view of the surrounding logic.
interface mem_req_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic [NUM_CH-1:0]                 req_valid;
    logic [NUM_CH-1:0]                 req_ready;
    logic [NUM_CH-1:0]                 req_we;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CH-1:0][MASK_WIDTH-1:0] req_wmask;
    logic [NUM_CH-1:0]                 resp_valid;
    logic [DATA_WIDTH-1:0]             resp_rdata;
    logic                              resp_err;

    logic                              m_req_valid;
    logic                              m_req_ready;
    logic                              m_req_we;
    logic [ADDR_WIDTH-1:0]             m_req_addr;
    logic [DATA_WIDTH-1:0]             m_req_wdata;
    logic [MASK_WIDTH-1:0]             m_req_wmask;
    logic                              m_resp_valid;
    logic [DATA_WIDTH-1:0]             m_resp_rdata;
    logic                              m_resp_err;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  m_req_ready, m_resp_valid, m_resp_rdata, m_resp_err,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wmask
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        output m_req_ready, m_resp_valid, m_resp_rdata, m_resp_err,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wmask
    );
endinterface

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first valid channel at or above
// rr_ptr, wrapping to channel 0.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [PW-1:0]     rr_ptr,
    output logic              found,
    output logic [PW-1:0]     grant_idx
);

    // Scan NUM_CH slots starting at rr_ptr; wrap by compare so odd counts work.
    always_comb begin
        int                idx;
        logic [NUM_CH-1:0] sh;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        sh        = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            sh = req_valid >> idx;
            if (!found && sh[0]) begin
                found     = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel round-robin memory request arbiter, one outstanding transaction.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int ADDR_WIDTH     = ARB_ADDR_W,
    parameter int DATA_WIDTH     = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
    input logic               clk,
    input logic               rstn,
    mem_req_arbiter_if.master bus
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MW = DATA_WIDTH / 8;

    arb_state_t            state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         gnt_q, gnt_d;
    arb_req_t              req_q, req_d;
    logic                  m_req_valid_q, m_req_valid_d;
    logic [NUM_CH-1:0]     resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [NUM_CH-1:0]     req_ready_c;
    logic [NUM_CH-1:0]     gnt_oh;
    logic                  pick_found;
    logic [PW-1:0]         pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt_q >= CW'(TIMEOUT_CYCLES - 1));
`endif

    rr_pick #(.NUM_CH(NUM_CH), .PW(PW)) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (pick_found),
        .grant_idx (pick_idx)
    );

    assign gnt_oh = NUM_CH'(1) << gnt_q;

    // Next-state and datapath latch selection; req_ready is the only
    // combinational output since the accept happens in the picking cycle.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        req_d         = req_q;
        m_req_valid_d = m_req_valid_q;
        resp_valid_d  = '0;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        req_ready_c   = '0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // rstn gate keeps req_ready quiet while the accept would be discarded
                if (pick_found && rstn) begin
                    req_ready_c   = NUM_CH'(1) << pick_idx;
                    gnt_d         = pick_idx;
                    req_d.we      = bus.req_we[pick_idx];
                    req_d.addr    = ARB_ADDR_W'(bus.req_addr[pick_idx]);
                    req_d.wdata   = ARB_DATA_W'(bus.req_wdata[pick_idx]);
                    req_d.wmask   = ARB_MASK_W'(bus.req_wmask[pick_idx]);
                    m_req_valid_d = 1'b1;
                    state_d       = ISSUE;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d     = '0;
`endif
                end
            end
            ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + CW'(1);
`endif
                if (bus.m_req_ready) begin
                    m_req_valid_d = 1'b0;
                    state_d       = WAIT_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    m_req_valid_d = 1'b0;
                    resp_rdata_d  = '0;
                    resp_err_d    = 1'b1;
                    resp_valid_d  = gnt_oh;
                    state_d       = RESPOND;
                end
`endif
            end
            WAIT_RESP: begin
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + CW'(1);
`endif
                if (bus.m_resp_valid) begin
                    resp_rdata_d = bus.m_resp_rdata;
                    resp_err_d   = bus.m_resp_err;
                    resp_valid_d = gnt_oh;
                    state_d      = RESPOND;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = gnt_oh;
                    state_d      = RESPOND;
                end
`endif
            end
            RESPOND: begin
                rr_ptr_d = PW'(rr_next(int'(gnt_q), NUM_CH));
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All state and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            req_q         <= '0;
            m_req_valid_q <= 1'b0;
            resp_valid_q  <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            req_q         <= req_d;
            m_req_valid_q <= m_req_valid_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.m_req_valid = m_req_valid_q;
    assign bus.m_req_we    = req_q.we;
    assign bus.m_req_addr  = ADDR_WIDTH'(req_q.addr);
    assign bus.m_req_wdata = DATA_WIDTH'(req_q.wdata);
    assign bus.m_req_wmask = MW'(req_q.wmask);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; timeout case runs when ARB_TIMEOUT_EN is defined.
module tb_mem_req_arbiter;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    mem_req_arbiter_if #(.NUM_CH(4), .ADDR_WIDTH(64), .DATA_WIDTH(128)) bus ();

    mem_req_arbiter #(
        .NUM_CH(4), .ADDR_WIDTH(64), .DATA_WIDTH(128), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0]  addr_tab [4];
    logic [127:0] wd_tab   [4];
    logic [15:0]  mk_tab   [4];
    logic         we_tab   [4];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i]  = addr_tab[i];
            bus.req_wdata[i] = wd_tab[i];
            bus.req_wmask[i] = mk_tab[i];
            bus.req_we[i]    = we_tab[i];
        end
    endtask

    // Called at the start of an IDLE cycle with req_valid already driven.
    // Ready downstream, response one cycle after issue; ends in next IDLE cycle.
    task automatic xact(input int g, input logic [127:0] rd, input logic err, input bit keep);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        #1;
        chk("grant", bus.req_ready, oh);
        step();
        if (!keep) bus.req_valid = '0;
        bus.m_req_ready = 1'b1;
        #1;
        chk("iss_vld", bus.m_req_valid, 1);
        chk("iss_addr", bus.m_req_addr, addr_tab[g]);
        chk("iss_we", bus.m_req_we, we_tab[g]);
        chk("iss_wdata", bus.m_req_wdata, wd_tab[g]);
        chk("iss_wmask", bus.m_req_wmask, mk_tab[g]);
        chk("iss_rdy", bus.req_ready, 0);
        step();
        bus.m_resp_valid = 1'b1;
        bus.m_resp_rdata = rd;
        bus.m_resp_err   = err;
        #1;
        chk("wait_mvld", bus.m_req_valid, 0);
        chk("wait_rvld", bus.resp_valid, 0);
        step();
        bus.m_resp_valid = 1'b0;
        #1;
        chk("rsp_vld", bus.resp_valid, oh);
        chk("rsp_data", bus.resp_rdata, rd);
        chk("rsp_err", bus.resp_err, err);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd1;
        rd1 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
        n_chk  = 0;
        n_fail = 0;
        addr_tab[0] = 64'h0000_0000_4000_0000; wd_tab[0] = 128'h0;          mk_tab[0] = 16'h0000; we_tab[0] = 1'b0;
        addr_tab[1] = 64'h0000_0000_4000_1000; wd_tab[1] = 128'h1111_2222;  mk_tab[1] = 16'hFFFF; we_tab[1] = 1'b1;
        addr_tab[2] = 64'h0000_0000_8000_0000; wd_tab[2] = 128'h0;          mk_tab[2] = 16'h0000; we_tab[2] = 1'b0;
        addr_tab[3] = 64'h0000_0000_4000_3000; wd_tab[3] = 128'hA5A5_5A5A;  mk_tab[3] = 16'h00FF; we_tab[3] = 1'b1;
        rstn             = 1'b0;
        bus.req_valid    = '0;
        bus.m_req_ready  = 1'b0;
        bus.m_resp_valid = 1'b0;
        bus.m_resp_rdata = '0;
        bus.m_resp_err   = 1'b0;
        load();

        // reset state
        step();
        step();
        #1;
        chk("rst_rdy", bus.req_ready, 0);
        chk("rst_rvld", bus.resp_valid, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_rerr", bus.resp_err, 0);
        chk("rst_mvld", bus.m_req_valid, 0);
        chk("rst_maddr", bus.m_req_addr, 0);
        chk("rst_mwe", bus.m_req_we, 0);
        chk("rst_mwdata", bus.m_req_wdata, 0);
        chk("rst_mwmask", bus.m_req_wmask, 0);

        // single ch2 read: accept T, issue T+1, response T+3
        step();
        rstn            = 1'b1;
        bus.req_valid   = 4'b0100;
        bus.m_req_ready = 1'b1;
        xact(2, rd1, 1'b0, 1'b0);
        #1;
        chk("hold_rvld", bus.resp_valid, 0);
        chk("hold_rdata", bus.resp_rdata, rd1);

        // all channels valid from reset: grants 0,1,2,3,0
        rstn = 1'b0;
        step();
        rstn          = 1'b1;
        bus.req_valid = 4'hF;
        xact(0, 128'h10, 1'b0, 1'b1);
        xact(1, 128'h11, 1'b0, 1'b1);
        xact(2, 128'h12, 1'b0, 1'b1);
        xact(3, 128'h13, 1'b0, 1'b1);
        xact(0, 128'h14, 1'b0, 1'b1);

        // downstream stall: rr_ptr=1, ch0 and ch3 valid -> ch3 granted and held
        bus.req_valid   = 4'b1001;
        bus.m_req_ready = 1'b0;
        #1;
        chk("stl_grant", bus.req_ready, 4'b1000);
        for (int k = 0; k < 6; k++) begin
            step();
            bus.m_req_ready = (k == 5);
            #1;
            chk("stl_mvld", bus.m_req_valid, 1);
            chk("stl_addr", bus.m_req_addr, addr_tab[3]);
            chk("stl_wdata", bus.m_req_wdata, wd_tab[3]);
            chk("stl_wmask", bus.m_req_wmask, mk_tab[3]);
            chk("stl_we", bus.m_req_we, 1);
            chk("stl_rdy", bus.req_ready, 0);
        end
        step();
        bus.m_resp_valid = 1'b1;
        bus.m_resp_rdata = 128'h33;
        bus.m_resp_err   = 1'b0;
        #1;
        chk("stl_wait", bus.m_req_valid, 0);
        step();
        bus.m_resp_valid = 1'b0;
        bus.req_valid    = 4'b0001;
        #1;
        chk("stl_rsp", bus.resp_valid, 4'b1000);
        step();
        xact(0, 128'h20, 1'b0, 1'b0);

        // ch1 write with downstream error; rr_ptr then points at 2
        bus.req_valid = 4'b0010;
        xact(1, 128'h0, 1'b1, 1'b0);

        // reset during WAIT_RESP, stale response afterwards
        bus.req_valid = 4'hF;
        #1;
        chk("ptr2_grant", bus.req_ready, 4'b0100);
        step();
        bus.m_req_ready = 1'b1;
        #1;
        chk("rw_mvld", bus.m_req_valid, 1);
        step();
        rstn = 1'b0;
        #1;
        chk("rw_wait", bus.m_req_valid, 0);
        step();
        rstn             = 1'b1;
        bus.req_valid    = '0;
        bus.m_resp_valid = 1'b1;
        bus.m_resp_rdata = 128'hBAD;
        #1;
        chk("rw_rvld0", bus.resp_valid, 0);
        chk("rw_rdata", bus.resp_rdata, 0);
        chk("rw_rerr", bus.resp_err, 0);
        step();
        #1;
        chk("rw_rvld1", bus.resp_valid, 0);
        step();
        bus.m_resp_valid = 1'b0;
        bus.req_valid    = 4'hF;
        xact(0, 128'h40, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // watchdog: downstream never answers, error response 8 cycles after ISSUE entry
        bus.req_valid = 4'b0010;
        #1;
        chk("to_grant", bus.req_ready, 4'b0010);
        step();
        bus.req_valid   = '0;
        bus.m_req_ready = 1'b1;
        #1;
        chk("to_mvld", bus.m_req_valid, 1);
        for (int k = 1; k < 8; k++) begin
            step();
            #1;
            chk("to_quiet", bus.resp_valid, 0);
        end
        step();
        #1;
        chk("to_rvld", bus.resp_valid, 4'b0010);
        chk("to_err", bus.resp_err, 1);
        chk("to_rdata", bus.resp_rdata, 0);
        step();
        bus.m_resp_valid = 1'b1;
        bus.m_resp_rdata = 128'h77;
        bus.m_resp_err   = 1'b0;
        #1;
        chk("to_late0", bus.resp_valid, 0);
        step();
        bus.m_resp_valid = 1'b0;
        #1;
        chk("to_late1", bus.resp_valid, 0);
        chk("to_hold", bus.resp_rdata, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
